telemetry_packetizer: RTL and testbench
=======================================

// Module: telemetry_packetizer
// PURPOSE
//   Frames fixed-width tracking samples (angle/magnitude words from the localisation
//   pipeline) into byte packets and feeds them one byte at a time to UARTInterface.
//   Sits directly upstream of UARTInterface: drives its data/data_rdy and honours tx_busy.
//   Packet = SYNC, SEQ, PAYLOAD_BYTES payload bytes (MSB first), CHECKSUM.
// PARAMETERS
//   PAYLOAD_BYTES  4      payload bytes per packet (>=1); PAYLOAD_W = 8*PAYLOAD_BYTES
//   SYNC_BYTE      8'hA5  first byte of every packet
// PORTS
//   clock         in   1          system clock
//   reset         in   1          synchronous, active-high reset
//   sample_valid  in   1          upstream sample present
//   sample_ready  out  1          block can take a sample this cycle
//   sample_data   in   PAYLOAD_W  sample to frame
//   data          out  8          byte to UARTInterface
//   data_rdy      out  1          data valid for UARTInterface
//   tx_busy       in   1          UARTInterface transmitting; byte not accepted while high
//   pkt_done      out  1          1-cycle pulse when the CHECKSUM byte is accepted
//   seq           out  8          sequence number of the current/next packet
// BEHAVIOUR
//   Reset: data=0, data_rdy=0, pkt_done=0, seq=0, sample_ready=1, holding reg empty, FSM IDLE.
//   Input buffer: one holding register. sample_ready = !hold_full.
//     Sample accepted on sample_valid && sample_ready; hold_full set next cycle.
//     Load (hold->packet) and a new accept in the same cycle are both legal; the new
//     sample lands in hold.
//   Byte handshake: a byte is accepted in the cycle data_rdy && !tx_busy.
//     UARTInterface raises tx_busy the cycle after acceptance, holds it until stop bit done.
//     data must stay stable while data_rdy=1 and tx_busy=1.
//   FSM:
//     IDLE: if hold_full -> copy hold into payload shift reg, clear hold, idx=0, csum=0, -> SEND.
//     SEND: data_rdy=1, data = byte[idx]; on acceptance -> SETTLE.
//     SETTLE: data_rdy=0 for exactly 1 cycle (covers tx_busy rise latency),
//       then idx++ -> SEND, or after last byte -> IDLE.
//   Byte order: idx0=SYNC_BYTE, idx1=seq, idx2..idx(PAYLOAD_BYTES+1)=payload MSB first,
//     last=csum. Total PAYLOAD_BYTES+3 bytes.
//   Checksum: 8-bit sum mod 256 of SEQ and all payload bytes; SYNC excluded.
//     Accumulated as bytes are accepted.
//   On CHECKSUM acceptance: pkt_done pulses for 1 cycle; seq increments, 8'hFF wraps to 8'h00.
//   Throughput: one byte per (UART frame time + 1 SETTLE cycle).
//     Next packet starts from IDLE the cycle after the last SETTLE if hold_full.
//   Payload snapshot is taken at load; sample_data changes afterwards do not affect
//     the packet in flight.
//   Reset mid-packet: packet abandoned, all state to reset values, pending sample discarded.
//     The next packet starts with SYNC, seq 0.
//   tx_busy high in IDLE or SETTLE is ignored; only SEND waits on it.
// TESTING
//   1 sample 32'h12345678 after reset, tx_busy model idle -> bytes A5 00 12 34 56 78 14;
//     pkt_done once; seq=1 after.
//   2 seq=01, sample 32'hFFFFFFFF -> A5 01 FF FF FF FF FD (sum 0x3FD truncated).
//   3 Three samples presented back-to-back:
//     #1 loads, #2 held (sample_ready=0), #3 stalls until #1 finishes;
//     packets emerge in order with seq 0,1,2.
//   4 Force tx_busy=1 for 500 cycles mid-packet -> data_rdy stays 1, data stable,
//     idx unchanged; resumes on release.
//   5 Send 256 packets of 32'h0 -> packet 255 is A5 FF 00 00 00 00 FF; packet 256 uses seq 00.
//   6 Assert reset during payload byte 2 -> all outputs to reset values next cycle;
//     new sample 32'h00000001 -> A5 00 00 00 00 01 01.

Source files
------------

// File: rtl/telemetry_packetizer.sv
// Frames fixed-width tracking samples into SYNC/SEQ/PAYLOAD/CHECKSUM byte packets
// and hands them one byte at a time to UARTInterface over a data_rdy/tx_busy handshake.
module telemetry_packetizer #(
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [8*PAYLOAD_BYTES-1:0]   sample_data,
  output logic [7:0]                   data,
  output logic                         data_rdy,
  input  logic                         tx_busy,
  output logic                         pkt_done,
  output logic [7:0]                   seq,
  output logic [1:0]                   dbg_state
);

  localparam int PAYLOAD_W = 8 * PAYLOAD_BYTES;
  localparam int IDX_W     = $clog2(PAYLOAD_BYTES + 3);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES + 2);
  localparam logic [IDX_W-1:0] FIRST_PAY = IDX_W'(2);

  // Handshakes: upstream sample moves on sample_valid && sample_ready; a byte moves
  // to the UART on data_rdy && !tx_busy, and data is held stable until that happens.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             csum_q, csum_d;
  logic [7:0]             data_q, data_d;
  logic                   data_rdy_q, data_rdy_d;
  logic                   pkt_done_q, pkt_done_d;
  logic [7:0]             seq_q, seq_d;

  logic                   accept;
  logic                   load;
  logic                   byte_acc;
  logic [IDX_W-1:0]       next_idx;
  logic [7:0]             next_byte;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    payload_d   = payload_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    data_d      = data_q;
    data_rdy_d  = data_rdy_q;
    pkt_done_d  = 1'b0;
    seq_d       = seq_q;
    load        = 1'b0;

    accept   = sample_valid && !hold_full_q;
    byte_acc = (state_q == SEND) && data_rdy_q && !tx_busy;
    next_idx = idx_q + IDX_W'(1);

    // The payload shift register always presents the next unsent payload byte on top.
    if (next_idx == IDX_W'(1)) begin
      next_byte = seq_q;
    end else if (next_idx == LAST_IDX) begin
      next_byte = csum_q;
    end else begin
      next_byte = payload_q[PAYLOAD_W-1 -: 8];
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load       = 1'b1;
          payload_d  = hold_q;
          idx_d      = '0;
          csum_d     = 8'h00;
          data_d     = SYNC_BYTE;
          data_rdy_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (byte_acc) begin
          data_rdy_d = 1'b0;
          state_d    = SETTLE;
          if (idx_q != '0 && idx_q != LAST_IDX) begin
            csum_d = csum_q + data_q;
          end
          if (idx_q >= FIRST_PAY && idx_q != LAST_IDX) begin
            payload_d = payload_q << 8;
          end
          if (idx_q == LAST_IDX) begin
            pkt_done_d = 1'b1;
            seq_d      = seq_q + 8'd1;
          end
        end
      end
      SETTLE: begin
        // One dead cycle lets the UART's tx_busy rise before the next byte is offered.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d      = next_idx;
          data_d     = next_byte;
          data_rdy_d = 1'b1;
          state_d    = SEND;
        end
      end
      default: begin
        state_d    = IDLE;
        data_rdy_d = 1'b0;
      end
    endcase

    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      payload_q   <= '0;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      data_q      <= 8'h00;
      data_rdy_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      seq_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      payload_q   <= payload_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      data_q      <= data_d;
      data_rdy_q  <= data_rdy_d;
      pkt_done_q  <= pkt_done_d;
      seq_q       <= seq_d;
    end
  end

  assign sample_ready = !hold_full_q;
  assign data         = data_q;
  assign data_rdy     = data_rdy_q;
  assign pkt_done     = pkt_done_q;
  assign seq          = seq_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Randomized bench for telemetry_packetizer: a UART model drives tx_busy, a packet
// model fills the expected byte queue, and a monitor checks every accepted byte.
module tb_telemetry_packetizer;

  localparam int         PB   = 4;
  localparam int         PW   = 8 * PB;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [PW-1:0] sample_data = '0;
  logic [7:0]    data;
  logic          data_rdy;
  logic          tx_busy = 1'b0;
  logic          pkt_done;
  logic [7:0]    seq;
  logic [1:0]    dbg_state;

  telemetry_packetizer #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .data         (data),
    .data_rdy     (data_rdy),
    .tx_busy      (tx_busy),
    .pkt_done     (pkt_done),
    .seq          (seq),
    .dbg_state    (dbg_state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_seq = 8'h00;
  bit force_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference packet: SYNC, SEQ, payload MSB first, then (SEQ + payload bytes) mod 256.
  task automatic push_packet(input logic [PW-1:0] d);
    int sum;
    logic [7:0] b;
    exp_q.push_back(SYNC);
    exp_q.push_back(model_seq);
    sum = int'(model_seq);
    for (int i = PB - 1; i >= 0; i--) begin
      b = d[8*i +: 8];
      exp_q.push_back(b);
      sum = sum + int'(b);
    end
    exp_q.push_back(8'(sum % 256));
    model_seq = model_seq + 8'd1;
  endtask

  // UART model and monitor, all at the falling edge.
  int         busy_cnt = 0;
  bit         acc_prev = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         byte_pos = 0;
  bit         expect_done = 1'b0;
  logic [7:0] mon_seq = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      busy_cnt    = 0;
      tx_busy     = 1'b0;
      acc_prev    = 1'b0;
      prev_hold   = 1'b0;
      byte_pos    = 0;
      expect_done = 1'b0;
      mon_seq     = 8'h00;
    end else begin
      if (prev_hold) check("hold_stable", {23'd0, data_rdy, data}, {23'd0, 1'b1, prev_data});
      if (expect_done || pkt_done) check("pkt_done", {31'd0, pkt_done}, {31'd0, expect_done});
      if (expect_done) check("seq_after_pkt", {24'd0, seq}, {24'd0, mon_seq});
      expect_done = 1'b0;
      if (acc_prev) busy_cnt = $urandom_range(1, 4);
      tx_busy = force_busy || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      acc_prev  = data_rdy && !tx_busy;
      prev_hold = data_rdy && tx_busy;
      prev_data = data;
      if (acc_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", data, $time);
        end else begin
          check("byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        byte_pos++;
        if (byte_pos == PB + 3) begin
          byte_pos    = 0;
          expect_done = 1'b1;
          mon_seq     = mon_seq + 8'd1;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the sample is taken.
  task automatic send_sample(input logic [PW-1:0] d);
    int guard = 0;
    sample_valid = 1'b1;
    sample_data  = d;
    while (!sample_ready && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (!sample_ready) begin
      fail_now("sample_accept");
    end else begin
      push_packet(d);
    end
    @(negedge clock);
    sample_data = $urandom;
  endtask

  task automatic idle_input();
    sample_valid = 1'b0;
    sample_data  = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || byte_pos != 0) && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0 || byte_pos != 0) fail_now("drain");
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while (byte_pos != p && guard < 5000) begin
      @(posedge clock);
      #2;
      guard++;
    end
    if (byte_pos != p) fail_now("wait_pos");
  endtask

  // Raises reset between edges, discards all pending expectations, checks reset outputs.
  task automatic do_reset();
    reset = 1'b1;
    idle_input();
    exp_q.delete();
    model_seq = 8'h00;
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_data_rdy", {31'd0, data_rdy}, 32'h0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'h0);
    check("rst_seq", {24'd0, seq}, 32'h0);
    check("rst_sample_ready", {31'd0, sample_ready}, 32'h1);
    check("rst_state", {30'd0, dbg_state}, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    do_reset();

    // Single packets, including the checksum-overflow case.
    send_sample(32'h12345678);
    idle_input();
    drain();
    send_sample(32'hFFFFFFFF);
    idle_input();
    drain();

    // Three back-to-back samples: second waits in hold, third stalls.
    send_sample(32'h0A0B0C0D);
    send_sample(32'h11223344);
    check("hold_full_ready", {31'd0, sample_ready}, 32'h0);
    send_sample(32'hDEADBEEF);
    idle_input();
    drain();

    // Long UART stall mid-packet.
    send_sample(32'hCAFE0042);
    idle_input();
    wait_pos(3);
    force_busy = 1'b1;
    repeat (500) @(posedge clock);
    #2;
    check("stall_data_rdy", {31'd0, data_rdy}, 32'h1);
    force_busy = 1'b0;
    drain();

    // Reset during a payload byte with a second sample pending in hold.
    send_sample(32'h55667788);
    send_sample(32'h99AABBCC);
    idle_input();
    wait_pos(3);
    do_reset();
    send_sample(32'h00000001);
    idle_input();
    drain();

    // Sequence wrap: 256 zero packets after the seq 0 packet above.
    for (int i = 0; i < 256; i++) send_sample(32'h0);
    idle_input();
    drain();

    // Random samples with random gaps.
    for (int i = 0; i < 30; i++) begin
      send_sample($urandom);
      idle_input();
      repeat ($urandom_range(0, 15)) @(negedge clock);
    end
    drain();

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
